// File: rtl/mem_responder_if.sv
// Byte-serial memory bus and host TX/RX byte ports shared by
// the core-side initiator and the memory responder.
interface mem_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic        io_tx_valid;
    logic [7:0]  io_tx_data;
    logic        io_tx_ready;
    logic        io_rx_valid;
    logic [7:0]  io_rx_data;
    logic        io_rx_ready;

    modport master (
        output mem_a, mem_dout, mem_wr,
        output io_tx_ready, io_rx_valid, io_rx_data,
        input  mem_din, rdy_out,
        input  io_tx_valid, io_tx_data, io_rx_ready
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr,
        input  io_tx_ready, io_rx_valid, io_rx_data,
        output mem_din, rdy_out,
        output io_tx_valid, io_tx_data, io_rx_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: 1-cycle RAM plus IO window (TX FIFO, RX holder, status, halt).
// Optional free-running cycle counter at 0x8..0xB when MEM_RESP_CYCLE_CNT_EN is defined.
module mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_AW    = 3
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    mem_responder_if.slave bus,
    output logic           sim_done
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   HI_WAT   = (FIFO_AW+1)'(DEPTH - 1);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [7:0]            ram_q;
    logic                  is_io;
    logic [3:0]            off;
    logic                  unused_a;

    logic [7:0]         fifo [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   tx_cnt;
    logic               tx_full;
    logic               overflow;
    logic               rx_full;
    logic [7:0]         rx_data;

    logic       wr_ok;
    logic       rd_ok;
    logic       ram_we;
    logic       tx_push_req;
    logic       tx_push;
    logic       tx_pop;
    logic       rx_load;
    logic       rx_pop;
    logic       halt;
    logic [7:0] io_rd;
    logic [7:0] io_q;
    logic       sel_io_q;
    logic [7:0] cnt_byte;

    assign ram_a    = bus.mem_a[ADDR_WIDTH-1:0];
    assign is_io    = bus.mem_a[17:16] == 2'b11;
    assign off      = bus.mem_a[3:0];
    assign unused_a = ^bus.mem_a[31:18];

    assign tx_full         = tx_cnt == FULL_CNT;
    assign bus.rdy_out     = tx_cnt < HI_WAT;
    assign bus.io_tx_valid = tx_cnt != '0;
    assign bus.io_tx_data  = fifo[rd_ptr];
    assign bus.io_rx_ready = !rx_full;

    // A frozen initiator keeps its address; gating on rdy_out keeps
    // every side effect to exactly one occurrence.
    assign wr_ok       = bus.rdy_out & bus.mem_wr;
    assign rd_ok       = bus.rdy_out & !bus.mem_wr;
    assign ram_we      = wr_ok & !is_io;
    assign tx_push_req = wr_ok & is_io & (off == 4'h0);
    assign halt        = wr_ok & is_io & (off == 4'h4);
    assign rx_pop      = rd_ok & is_io & (off == 4'h0) & rx_full;
    assign rx_load     = bus.io_rx_valid & bus.io_rx_ready;
    assign tx_pop      = bus.io_tx_valid & bus.io_tx_ready;
    assign tx_push     = tx_push_req & (!tx_full | tx_pop);

`ifdef MEM_RESP_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cyc_cnt <= '0;
        else           cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign cnt_byte = 8'(cyc_cnt >> {off[1:0], 3'b000});
`else
    assign cnt_byte = 8'h00;
`endif

    always_comb begin
        io_rd = 8'h00;
        unique case (off)
            4'h0:    io_rd = rx_full ? rx_data : 8'h00;
            4'h4:    io_rd = {5'b0, overflow, rx_full, tx_full};
            4'h8,
            4'h9,
            4'hA,
            4'hB:    io_rd = cnt_byte;
            default: io_rd = 8'h00;
        endcase
    end

    // Read-before-write: a write cycle returns the old byte.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_a] <= bus.mem_dout;
        ram_q <= ram[ram_a];
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) fifo[wr_ptr] <= bus.mem_dout;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_io_q <= 1'b1;
            io_q     <= 8'h00;
            sim_done <= 1'b0;
        end else begin
            sel_io_q <= is_io;
            io_q     <= io_rd;
            sim_done <= halt;
        end
    end

    assign bus.mem_din = sel_io_q ? io_q : ram_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
            if (tx_push_req & tx_full & !tx_pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_full <= 1'b0;
            rx_data <= 8'h00;
        end else if (rx_load) begin
            rx_full <= 1'b1;
            rx_data <= bus.io_rx_data;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, corner
// sequences and randomized traffic against a queue-based model.
module tb_mem_responder;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sim_done;

    mem_responder_if bus();

    mem_responder #(.ADDR_WIDTH(17), .FIFO_AW(3)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus),
        .sim_done(sim_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mram [int];
    logic [7:0]  tq [$];
    logic [7:0]  dut_tx [$];
    bit          rxf;
    logic [7:0]  rxd;
    bit          ovf;
    int unsigned cnt_m;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        bit          w;
        bit          ck;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    function automatic logic [7:0] cnt_exp(input logic [3:0] off);
`ifdef MEM_RESP_CYCLE_CNT_EN
        return 8'(cnt_m >> (8 * (int'(off) - 8)));
`else
        return 8'h00;
`endif
    endfunction

    task automatic cyc(input logic [31:0] a, input logic [7:0] d, input bit w);
        bit io, r, full0, rxf0, pop, push_req, sd_e, ek;
        logic [3:0]  off;
        logic [16:0] idx;
        logic [7:0]  e;
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.mem_wr   = w;
        idx = a[16:0];
        io  = a[17:16] == 2'b11;
        off = a[3:0];
        r   = tq.size() < DEPTH - 1;
        ek  = 1'b1;
        e   = 8'h00;
        if (io) begin
            if (off == 4'h0)      e = rxf ? rxd : 8'h00;
            else if (off == 4'h4) e = {5'b0, ovf, rxf, tq.size() == DEPTH};
            else if (off >= 4'h8 && off <= 4'hB) e = cnt_exp(off);
        end else if (mram.exists(int'(idx))) begin
            e = mram[int'(idx)];
        end else begin
            ek = 1'b0;
        end
        full0    = tq.size() == DEPTH;
        rxf0     = rxf;
        pop      = tq.size() != 0 && bus.io_tx_ready;
        push_req = r && w && io && off == 4'h0;
        if (bus.io_tx_valid && bus.io_tx_ready) dut_tx.push_back(bus.io_tx_data);
        if (r && w && !io) mram[int'(idx)] = d;
        if (pop) void'(tq.pop_front());
        if (push_req) begin
            if (!full0 || pop) tq.push_back(d);
            else ovf = 1'b1;
        end
        if (r && !w && io && off == 4'h0 && rxf0) rxf = 1'b0;
        if (bus.io_rx_valid && !rxf0) begin
            rxf = 1'b1;
            rxd = bus.io_rx_data;
        end
        sd_e = r && w && io && off == 4'h4;
        @(posedge clk);
        #1;
        cnt_m++;
        if (ek) chk("mem_din", 32'(bus.mem_din), 32'(e));
        chk("rdy_out", 32'(bus.rdy_out), 32'(tq.size() < DEPTH - 1));
        chk("tx_valid", 32'(bus.io_tx_valid), 32'(tq.size() != 0));
        if (tq.size() != 0) chk("tx_data", 32'(bus.io_tx_data), 32'(tq[0]));
        chk("rx_ready", 32'(bus.io_rx_ready), 32'(!rxf));
        chk("sim_done", 32'(sim_done), 32'(sd_e));
    endtask

    task automatic idle();
        cyc(32'h0003_0002, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_din", 32'(bus.mem_din), 32'h0);
        chk("rst_rdy", 32'(bus.rdy_out), 32'h1);
        chk("rst_tx_valid", 32'(bus.io_tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(bus.io_rx_ready), 32'h1);
        chk("rst_sim_done", 32'(sim_done), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tq.delete();
        dut_tx.delete();
        rxf   = 1'b0;
        ovf   = 1'b0;
        cnt_m = 0;
    endtask

    initial begin
        bit done;
        tbl[0]  = '{32'h0000_0010, 8'hA5, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'hA5};
        tbl[2]  = '{32'hFFF8_0012, 8'h3C, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{32'h0000_0012, 8'h00, 1'b0, 1'b1, 8'h3C};
        tbl[4]  = '{32'h0002_0012, 8'h00, 1'b0, 1'b1, 8'h3C};
        tbl[5]  = '{32'h0000_0010, 8'h77, 1'b1, 1'b1, 8'hA5};
        tbl[6]  = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'h77};
        tbl[7]  = '{32'h0003_0004, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[8]  = '{32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[9]  = '{32'h0003_0001, 8'h55, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{32'h0003_0001, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[11] = '{32'h0003_000F, 8'h00, 1'b0, 1'b1, 8'h00};

        bus.mem_a       = 32'h0;
        bus.mem_dout    = 8'h0;
        bus.mem_wr      = 1'b0;
        bus.io_tx_ready = 1'b0;
        bus.io_rx_valid = 1'b0;
        bus.io_rx_data  = 8'h0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].a, tbl[i].d, tbl[i].w);
            if (tbl[i].ck) chk($sformatf("vec%0d", i), 32'(bus.mem_din), 32'(tbl[i].exp));
        end

        // TX fill, stall on the 8th write, release in order
        dut_tx.delete();
        bus.io_tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(32'h0003_0000, 8'(8'h40 + i), 1'b1);
            chk("rdy_fill", 32'(bus.rdy_out), 32'(i < 6));
        end
        repeat (3) cyc(32'h0003_0000, 8'h47, 1'b1);
        chk("rdy_held", 32'(bus.rdy_out), 32'h0);
        bus.io_tx_ready = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            bit pre;
            pre = bus.rdy_out;
            cyc(32'h0003_0000, 8'h47, 1'b1);
            if (pre) done = 1'b1;
        end
        chk("held_push_done", 32'(done), 32'h1);
        for (int t = 0; t < 20 && bus.io_tx_valid; t++) idle();
        chk("drain_empty", 32'(bus.io_tx_valid), 32'h0);
        chk("rdy_back", 32'(bus.rdy_out), 32'h1);
        chk("tx_count8", 32'(dut_tx.size()), 32'd8);
        for (int k = 0; k < dut_tx.size() && k < 8; k++)
            chk($sformatf("tx_order%0d", k), 32'(dut_tx[k]), 32'(8'h40 + k));

        // Nine writes ignoring rdy: only seven are accepted, no overflow
        dut_tx.delete();
        bus.io_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cyc(32'h0003_0000, 8'(8'h50 + i), 1'b1);
        cyc(32'h0003_0004, 8'h00, 1'b0);
        chk("status_after9", 32'(bus.mem_din), 32'h00);
        bus.io_tx_ready = 1'b1;
        for (int t = 0; t < 20 && bus.io_tx_valid; t++) idle();
        chk("tx_count7", 32'(dut_tx.size()), 32'd7);
        for (int k = 0; k < dut_tx.size() && k < 7; k++)
            chk($sformatf("tx9_order%0d", k), 32'(dut_tx[k]), 32'(8'h50 + k));

        // RX holder load, status, pop, empty reread
        bus.io_rx_valid = 1'b1;
        bus.io_rx_data  = 8'h5A;
        idle();
        bus.io_rx_valid = 1'b0;
        chk("rx_full_rdy", 32'(bus.io_rx_ready), 32'h0);
        cyc(32'h0003_0004, 8'h00, 1'b0);
        chk("status_rx", 32'(bus.mem_din), 32'h02);
        cyc(32'h0003_0000, 8'h00, 1'b0);
        chk("rx_read", 32'(bus.mem_din), 32'h5A);
        cyc(32'h0003_0000, 8'h00, 1'b0);
        chk("rx_reread", 32'(bus.mem_din), 32'h00);
        chk("rx_ready_again", 32'(bus.io_rx_ready), 32'h1);

        // Halt pulse
        cyc(32'h0003_0004, 8'h00, 1'b1);
        chk("halt_pulse", 32'(sim_done), 32'h1);
        idle();
        chk("halt_clear", 32'(sim_done), 32'h0);

        // Reset mid-transfer discards TX and RX state
        bus.io_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(32'h0003_0000, 8'(8'h60 + i), 1'b1);
        bus.io_rx_valid = 1'b1;
        bus.io_rx_data  = 8'hC3;
        idle();
        bus.io_rx_valid = 1'b0;
        do_reset();
        idle();
        chk("post_rst_tx", 32'(bus.io_tx_valid), 32'h0);
        cyc(32'h0003_0000, 8'h00, 1'b0);
        chk("post_rst_rx", 32'(bus.mem_din), 32'h00);

        // Cycle counter read at cycle 100 after reset
        do_reset();
        repeat (100) idle();
        cyc(32'h0003_0008, 8'h00, 1'b0);
`ifdef MEM_RESP_CYCLE_CNT_EN
        chk("cnt100", 32'(bus.mem_din), 32'd100);
`else
        chk("cnt100", 32'(bus.mem_din), 32'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [7:0]  d;
            bit          w;
            int          k;
            k = $urandom_range(0, 9);
            a = $urandom();
            if (k < 5) begin
                a[16:0] = 17'($urandom_range(0, 31));
            end else begin
                a[17:16] = 2'b11;
                case (k)
                    5, 6:    a[3:0] = 4'h0;
                    7:       a[3:0] = 4'h4;
                    8:       a[3:0] = 4'(8 + $urandom_range(0, 3));
                    default: a[3:0] = 4'($urandom_range(0, 15));
                endcase
            end
            w = $urandom_range(0, 2) == 0;
            d = 8'($urandom());
            bus.io_tx_ready = 1'($urandom_range(0, 1));
            bus.io_rx_valid = $urandom_range(0, 3) == 0;
            bus.io_rx_data  = 8'($urandom());
            cyc(a, d, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
